riscv_ctrl_multicycle: RTL

- Moore/Mealy control FSM that sequences a multicycle RV32I datapath.
- The datapath has one shared memory port, one ALU, IR/PC/old-PC/ALUOut/data registers, and the regfile.
- Per cycle, the block decodes the latched instruction fields and drives mux selects, register write enables, memory write and ALU control.
- It holds FETCH and memory states until the memory handshake completes.

---
 rtl/riscv_ctrl_multicycle.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_ctrl_multicycle.sv
// Control FSM for a multicycle RV32I datapath with a shared memory port and a bounded memory wait.
// Optional feature: define RISCV_CTRL_PERF_CNT_EN to add 64-bit cycle and retired-instruction counters.
module riscv_ctrl_multicycle #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [6:0] i_ctrl_opcode,
  input  logic [2:0] i_ctrl_funct3,
  input  logic       i_ctrl_funct7_5,
  input  logic       i_ctrl_alu_zero,
  input  logic       i_ctrl_mem_ready,
  output logic       o_ctrl_pc_wen,
  output logic       o_ctrl_ir_wen,
  output logic       o_ctrl_adr_src,
  output logic       o_ctrl_mem_req,
  output logic       o_ctrl_mem_wen,
  output logic       o_ctrl_regfile_wen,
  output logic [1:0] o_ctrl_src_alu_a,
  output logic [1:0] o_ctrl_src_alu_b,
  output logic [1:0] o_ctrl_src_rd,
  output logic [2:0] o_ctrl_src_imm,
  output logic [3:0] o_ctrl_alu_ctrl,
  output logic       o_ctrl_illegal,
  output logic       o_ctrl_timeout
`ifdef RISCV_CTRL_PERF_CNT_EN
  ,
  output logic [63:0] o_ctrl_cycle_cnt,
  output logic [63:0] o_ctrl_instret_cnt
`endif
);

  localparam logic [3:0] FETCH = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
                         MEMWR = 4'd4,  MEMWB  = 4'd5,  EXE_R  = 4'd6,  EXE_I = 4'd7,
                         EXE_U = 4'd8,  ALUWB  = 4'd9,  JAL    = 4'd10, JALR  = 4'd11,
                         JALR_LINK = 4'd12, BRANCH = 4'd13;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
                         OP_I    = 7'b0010011, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL  = 7'b1101111, OP_JALR  = 7'b1100111, OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = (MEM_WAIT_MAX == 0) ? '0 : CW'(MEM_WAIT_MAX - 1);

  logic [3:0]    state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          pc_wen, ir_wen, adr_src, mem_req, mem_wen, rf_wen, illegal, timeout;
  logic [1:0]    src_a, src_b, src_rd;
  logic [2:0]    src_imm;
  logic [3:0]    alu;
  logic          mem_wait, taken;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    pc_wen  = 1'b0;
    ir_wen  = 1'b0;
    adr_src = 1'b0;
    mem_req = 1'b0;
    mem_wen = 1'b0;
    rf_wen  = 1'b0;
    illegal = 1'b0;
    src_a   = 2'b00;
    src_b   = 2'b00;
    src_rd  = 2'b00;
    src_imm = 3'b000;
    alu     = ALU_ADD;
    taken   = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        src_b   = 2'b10;
        src_rd  = 2'b10;
        ir_wen  = i_ctrl_mem_ready;
        pc_wen  = i_ctrl_mem_ready;
        if (i_ctrl_mem_ready) state_next = DECODE;
      end
      DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        src_imm = (i_ctrl_opcode == OP_JAL) ? 3'b100 : 3'b010;
        case (i_ctrl_opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXE_R;
          OP_I:              state_next = EXE_I;
          OP_LUI, OP_AUIPC:  state_next = EXE_U;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_BRANCH:         state_next = BRANCH;
          default: begin
            illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        src_imm    = (i_ctrl_opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_next = (i_ctrl_opcode == OP_STORE) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (i_ctrl_mem_ready) state_next = MEMWB;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_wen = 1'b1;
        adr_src = 1'b1;
        if (i_ctrl_mem_ready) state_next = FETCH;
      end
      MEMWB: begin
        src_rd     = 2'b01;
        rf_wen     = 1'b1;
        state_next = FETCH;
      end
      EXE_R: begin
        src_a      = 2'b10;
        alu        = alu_op(i_ctrl_funct3, i_ctrl_funct7_5);
        state_next = ALUWB;
      end
      EXE_I: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        alu        = alu_op(i_ctrl_funct3, i_ctrl_funct7_5 && (i_ctrl_funct3 == 3'b101));
        state_next = ALUWB;
      end
      EXE_U: begin
        src_a      = (i_ctrl_opcode == OP_LUI) ? 2'b11 : 2'b01;
        src_b      = 2'b01;
        src_imm    = 3'b011;
        state_next = ALUWB;
      end
      ALUWB: begin
        rf_wen     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        pc_wen     = 1'b1;
        state_next = ALUWB;
      end
      JALR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        src_rd     = 2'b10;
        pc_wen     = 1'b1;
        state_next = JALR_LINK;
      end
      JALR_LINK: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        state_next = ALUWB;
      end
      BRANCH: begin
        src_a = 2'b10;
        case (i_ctrl_funct3[2:1])
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: alu = ALU_SUB;
        endcase
        // Equality tests branch on zero; ordered compares branch on a nonzero SLT/SLTU result.
        taken      = (i_ctrl_funct3[2] ? ~i_ctrl_alu_zero : i_ctrl_alu_zero) ^ i_ctrl_funct3[0];
        pc_wen     = taken;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    mem_wait = mem_req & ~i_ctrl_mem_ready;
    timeout  = (MEM_WAIT_MAX != 0) && mem_wait && (wait_cnt == WAIT_LAST);
    if (timeout) begin
      state_next = FETCH;
      pc_wen     = 1'b0;
      ir_wen     = 1'b0;
      mem_wen    = 1'b0;
      rf_wen     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || timeout)
        wait_cnt <= '0;
      else if (mem_wait && (MEM_WAIT_MAX != 0))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

`ifdef RISCV_CTRL_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ctrl_cycle_cnt   <= '0;
      o_ctrl_instret_cnt <= '0;
    end else begin
      o_ctrl_cycle_cnt <= o_ctrl_cycle_cnt + 64'd1;
      if ((state_next == FETCH) && (state != FETCH) && !illegal && !timeout)
        o_ctrl_instret_cnt <= o_ctrl_instret_cnt + 64'd1;
    end
  end
`endif

  // Enables and pulses are forced low combinationally so reset takes effect without a clock edge.
  assign o_ctrl_pc_wen      = pc_wen  & i_rstn;
  assign o_ctrl_ir_wen      = ir_wen  & i_rstn;
  assign o_ctrl_adr_src     = adr_src;
  assign o_ctrl_mem_req     = mem_req & i_rstn;
  assign o_ctrl_mem_wen     = mem_wen & i_rstn;
  assign o_ctrl_regfile_wen = rf_wen  & i_rstn;
  assign o_ctrl_src_alu_a   = src_a;
  assign o_ctrl_src_alu_b   = src_b;
  assign o_ctrl_src_rd      = src_rd;
  assign o_ctrl_src_imm     = src_imm;
  assign o_ctrl_alu_ctrl    = alu;
  assign o_ctrl_illegal     = illegal & i_rstn;
  assign o_ctrl_timeout     = timeout & i_rstn;

endmodule
